// File: rtl/memmu_sr_writer_pkg.sv
// memmu_sr_writer_pkg
// Shared definitions for the spherical-representation memory writer:
// FSM state encoding, payload byte-shift constant, counter widths and
// the slot address helper.
// Build option: MEMMU_SR_WRITER_CLEAR_EN adds the CLEAR (zero-fill) state.
package memmu_sr_writer_pkg;

  localparam int PAYLOAD_BYTE_SHIFT = 3;   // 8-byte payload per slot
  localparam int PAYLOAD_W          = 64;
  localparam int MEM_ADDR_W         = 32;
  localparam int SR_INDEX_W         = 19;
  localparam int POINT_CNT_W        = 32;
  localparam int DROP_CNT_W         = 16;

`ifdef MEMMU_SR_WRITER_CLEAR_EN
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_CLEAR  = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DRAIN  = 2'd2
  } state_t;
`endif

  // Byte address of a representation slot; wraps modulo 2^32.
  function automatic logic [MEM_ADDR_W-1:0] slot_addr(input logic [MEM_ADDR_W-1:0] base,
                                                      input logic [MEM_ADDR_W-1:0] idx);
    return base + (idx << PAYLOAD_BYTE_SHIFT);
  endfunction

endpackage

// File: rtl/memmu_sr_writer_fifo.sv
// memmu_sr_writer_fifo
// Synchronous point buffer. Storage and flags are registers, so head_data
// and the full/empty flags come straight from flops.
// Ports:
//   clk, rst        clock, synchronous active-high reset (empties the FIFO)
//   push, push_data write side; push ignored when full
//   pop             read side; pop ignored when empty
//   head_data       oldest entry
//   full, empty     status flags
module memmu_sr_writer_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             do_push, do_pop;

  // Extra pointer MSB distinguishes full from empty when the low bits match.
  assign empty     = (wr_ptr_q == rd_ptr_q);
  assign full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign head_data = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    do_push  = push && !full;
    do_pop   = pop && !empty;
    wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= push_data;
    end
  end

endmodule

// File: rtl/memmu_sr_writer.sv
// memmu_sr_writer
// Buffers points from the spherical representation stage and writes their
// payloads to memory at base + index*8. Optionally zero-fills the whole
// representation at the start of every frame.
// Build option: MEMMU_SR_WRITER_CLEAR_EN enables the CLEAR zero-fill state.
// Ports:
//   i_SYSTEM_clk / i_SYSTEM_rst         clock, synchronous active-high reset
//   i_SIU_frameStart                    new-frame pulse
//   i_CFG_baseAddr                      representation base (sampled per frame)
//   i_MemMU_SR_valid/o_MemMU_SR_ready   point handshake
//   i_MemMU_SR_address/_payload         point index and data
//   o_MEM_wrValid/i_MEM_wrReady         memory write handshake
//   o_MEM_wrAddr/o_MEM_wrData           write address and data
//   o_busy                              DRAIN or CLEAR in progress
//   o_pointCount / o_dropCount          frame write count / discarded points
//
// state  | meaning
// IDLE   | no frame yet; points accepted and dropped
// STREAM | points buffered and written out
// DRAIN  | frame ended; flushing buffered points of the old frame
// CLEAR  | zero-filling every slot of the new frame (optional)
module memmu_sr_writer
  import memmu_sr_writer_pkg::*;
#(
  parameter int NUMBER_OF_ADDR_BITS = 16,
  parameter int FIFO_DEPTH          = 16
) (
  input  logic                   i_SYSTEM_clk,
  input  logic                   i_SYSTEM_rst,
  input  logic                   i_SIU_frameStart,
  input  logic [MEM_ADDR_W-1:0]  i_CFG_baseAddr,
  input  logic                   i_MemMU_SR_valid,
  output logic                   o_MemMU_SR_ready,
  input  logic [SR_INDEX_W-1:0]  i_MemMU_SR_address,
  input  logic [PAYLOAD_W-1:0]   i_MemMU_SR_payload,
  output logic                   o_MEM_wrValid,
  input  logic                   i_MEM_wrReady,
  output logic [MEM_ADDR_W-1:0]  o_MEM_wrAddr,
  output logic [PAYLOAD_W-1:0]   o_MEM_wrData,
  output logic                   o_busy,
  output logic [POINT_CNT_W-1:0] o_pointCount,
  output logic [DROP_CNT_W-1:0]  o_dropCount
);

  localparam int N       = NUMBER_OF_ADDR_BITS;
  localparam int ENTRY_W = N + PAYLOAD_W;

  state_t                 state_q, state_d;
  logic [MEM_ADDR_W-1:0]  base_q, base_d;
  logic [MEM_ADDR_W-1:0]  base_pend_q, base_pend_d;
  logic [POINT_CNT_W-1:0] point_cnt_q, point_cnt_d;
  logic [DROP_CNT_W-1:0]  drop_cnt_q, drop_cnt_d;
`ifdef MEMMU_SR_WRITER_CLEAR_EN
  logic [N-1:0]           clr_idx_q, clr_idx_d;
`endif

  logic               ready_c, wr_valid_c;
  logic [MEM_ADDR_W-1:0] wr_addr_c;
  logic [PAYLOAD_W-1:0]  wr_data_c;
  logic               fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [ENTRY_W-1:0] fifo_head;
  logic [N-1:0]       head_idx;
  logic [PAYLOAD_W-1:0] head_payload;
  logic               unused_addr_hi;

  // Index bits at and above N do not take part in addressing.
  assign unused_addr_hi = ^(i_MemMU_SR_address >> N);
  assign {head_idx, head_payload} = fifo_head;

  memmu_sr_writer_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (i_SYSTEM_clk),
    .rst       (i_SYSTEM_rst),
    .push      (fifo_push),
    .push_data ({i_MemMU_SR_address[N-1:0], i_MemMU_SR_payload}),
    .pop       (fifo_pop),
    .head_data (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    base_pend_d = base_pend_q;
    point_cnt_d = point_cnt_q;
    drop_cnt_d  = drop_cnt_q;
`ifdef MEMMU_SR_WRITER_CLEAR_EN
    clr_idx_d   = clr_idx_q;
`endif
    ready_c    = 1'b0;
    fifo_push  = 1'b0;
    fifo_pop   = 1'b0;
    wr_valid_c = 1'b0;
    wr_addr_c  = '0;
    wr_data_c  = '0;

    case (state_q)
      ST_IDLE: begin
        ready_c = 1'b1;
        if (i_MemMU_SR_valid && (drop_cnt_q != '1)) begin
          drop_cnt_d = drop_cnt_q + 16'd1;
        end
        if (i_SIU_frameStart) begin
          base_d      = i_CFG_baseAddr;
          point_cnt_d = '0;
`ifdef MEMMU_SR_WRITER_CLEAR_EN
          clr_idx_d   = '0;
          state_d     = ST_CLEAR;
`else
          state_d     = ST_STREAM;
`endif
        end
      end
      ST_STREAM: begin
        // Ready depends only on the registered full flag: a pop never
        // opens a slot for a push in the same cycle.
        ready_c   = !fifo_full;
        fifo_push = i_MemMU_SR_valid && !fifo_full;
        if (i_SIU_frameStart) begin
          // The old frame's points still drain against base_q.
          base_pend_d = i_CFG_baseAddr;
          state_d     = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (fifo_empty) begin
          base_d      = base_pend_q;
          point_cnt_d = '0;
`ifdef MEMMU_SR_WRITER_CLEAR_EN
          clr_idx_d   = '0;
          state_d     = ST_CLEAR;
`else
          state_d     = ST_STREAM;
`endif
        end
      end
`ifdef MEMMU_SR_WRITER_CLEAR_EN
      ST_CLEAR: begin
        wr_valid_c = 1'b1;
        wr_addr_c  = slot_addr(base_q, 32'(clr_idx_q));
        if (i_MEM_wrReady) begin
          if (clr_idx_q == {N{1'b1}}) begin
            state_d = ST_STREAM;
          end else begin
            clr_idx_d = clr_idx_q + N'(1);
          end
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase

    // Data writes: the FIFO head is presented directly and held until taken.
    if (((state_q == ST_STREAM) || (state_q == ST_DRAIN)) && !fifo_empty) begin
      wr_valid_c = 1'b1;
      wr_addr_c  = slot_addr(base_q, 32'(head_idx));
      wr_data_c  = head_payload;
      if (i_MEM_wrReady) begin
        fifo_pop = 1'b1;
        if (point_cnt_q != '1) begin
          point_cnt_d = point_cnt_q + 32'd1;
        end
      end
    end
  end

  always_ff @(posedge i_SYSTEM_clk) begin
    if (i_SYSTEM_rst) begin
      state_q     <= ST_IDLE;
      base_q      <= '0;
      base_pend_q <= '0;
      point_cnt_q <= '0;
      drop_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      base_pend_q <= base_pend_d;
      point_cnt_q <= point_cnt_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

`ifdef MEMMU_SR_WRITER_CLEAR_EN
  always_ff @(posedge i_SYSTEM_clk) begin
    if (i_SYSTEM_rst) begin
      clr_idx_q <= '0;
    end else begin
      clr_idx_q <= clr_idx_d;
    end
  end
`endif

  assign o_MemMU_SR_ready = ready_c && !i_SYSTEM_rst;
  assign o_MEM_wrValid    = wr_valid_c;
  assign o_MEM_wrAddr     = wr_addr_c;
  assign o_MEM_wrData     = wr_data_c;
  assign o_busy           = (state_q != ST_IDLE) && (state_q != ST_STREAM);
  assign o_pointCount     = point_cnt_q;
  assign o_dropCount      = drop_cnt_q;

endmodule

// File: tb/tb_memmu_sr_writer.sv
// tb_memmu_sr_writer
// Directed bench for memmu_sr_writer (N=4, FIFO_DEPTH=16). Covers the
// default build and, when MEMMU_SR_WRITER_CLEAR_EN is defined, the
// zero-fill sequences.
module tb_memmu_sr_writer;

  logic        clk;
  logic        rst;
  logic        frame_start;
  logic [31:0] cfg_base;
  logic        sr_valid;
  logic        sr_ready;
  logic [18:0] sr_addr;
  logic [63:0] sr_payload;
  logic        wr_valid;
  logic        wr_ready;
  logic [31:0] wr_addr;
  logic [63:0] wr_data;
  logic        busy;
  logic [31:0] point_count;
  logic [15:0] drop_count;

  int checks = 0;
  int errors = 0;
  int cyc_cnt = 0;

  logic [31:0] log_addr[$];
  logic [63:0] log_data[$];
  int          log_cyc[$];

  typedef struct {
    logic [18:0] idx;
    logic [63:0] payload;
    logic [31:0] exp_addr;
  } vec_t;
  vec_t vecs[6];

  memmu_sr_writer #(
    .NUMBER_OF_ADDR_BITS (4),
    .FIFO_DEPTH          (16)
  ) dut (
    .i_SYSTEM_clk       (clk),
    .i_SYSTEM_rst       (rst),
    .i_SIU_frameStart   (frame_start),
    .i_CFG_baseAddr     (cfg_base),
    .i_MemMU_SR_valid   (sr_valid),
    .o_MemMU_SR_ready   (sr_ready),
    .i_MemMU_SR_address (sr_addr),
    .i_MemMU_SR_payload (sr_payload),
    .o_MEM_wrValid      (wr_valid),
    .i_MEM_wrReady      (wr_ready),
    .o_MEM_wrAddr       (wr_addr),
    .o_MEM_wrData       (wr_data),
    .o_busy             (busy),
    .o_pointCount       (point_count),
    .o_dropCount        (drop_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  // Write log: a handshake seen at the falling edge completes on the next rising edge.
  always @(negedge clk) begin
    if (!rst && wr_valid && wr_ready) begin
      log_addr.push_back(wr_addr);
      log_data.push_back(wr_data);
      log_cyc.push_back(cyc_cnt);
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_writes(input string name, input int n, input int budget);
    int c = 0;
    while ((log_addr.size() < n) && (c < budget)) begin
      cyc();
      c++;
    end
    chk(name, 64'(log_addr.size()), 64'(n));
  endtask

  task automatic clear_log();
    log_addr.delete();
    log_data.delete();
    log_cyc.delete();
  endtask

  task automatic chk_write(input string name, input int i, input logic [31:0] ea, input logic [63:0] ed);
    if (i < log_addr.size()) begin
      chk({name, "_addr"}, 64'(log_addr[i]), 64'(ea));
      chk({name, "_data"}, log_data[i], ed);
    end else begin
      chk({name, "_missing"}, 64'(log_addr.size()), 64'(i + 1));
    end
  endtask

  task automatic push_point(input logic [18:0] idx, input logic [63:0] pl);
    sr_valid   = 1'b1;
    sr_addr    = idx;
    sr_payload = pl;
    cyc();
    sr_valid   = 1'b0;
  endtask

  initial begin
    int k;
    int unstable;
    logic [31:0] first_addr;
    logic [63:0] first_data;
    logic        acc;

    vecs[0] = '{19'h00000, 64'h0000_0000_0000_000A, 32'h1000_0000};
    vecs[1] = '{19'h00001, 64'h0000_0000_0000_000B, 32'h1000_0008};
    vecs[2] = '{19'h00005, 64'h0000_0000_0000_000C, 32'h1000_0028};
    vecs[3] = '{19'h00015, 64'h0000_0000_0000_000D, 32'h1000_0028};
    vecs[4] = '{19'h7FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 32'h1000_0078};
    vecs[5] = '{19'h00008, 64'h0123_4567_89AB_CDEF, 32'h1000_0040};

    rst = 1'b1; frame_start = 1'b0; cfg_base = '0;
    sr_valid = 1'b0; sr_addr = '0; sr_payload = '0; wr_ready = 1'b1;

    // Reset state
    repeat (3) cyc();
    chk("ready_in_reset", 64'(sr_ready), 64'd0);
    rst = 1'b0;
    cyc();
    chk("rst_wrvalid", 64'(wr_valid), 64'd0);
    chk("rst_wraddr", 64'(wr_addr), 64'd0);
    chk("rst_wrdata", wr_data, 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_pointcount", 64'(point_count), 64'd0);
    chk("rst_dropcount", 64'(drop_count), 64'd0);
    chk("idle_ready", 64'(sr_ready), 64'd1);

    // IDLE: five points dropped
    for (int i = 0; i < 5; i++) begin
      sr_valid = 1'b1; sr_addr = 19'(i); sr_payload = 64'(i);
      cyc();
    end
    sr_valid = 1'b0;
    chk("idle_dropcount", 64'(drop_count), 64'd5);
    chk("idle_no_writes", 64'(log_addr.size()), 64'd0);

    // Frame start from IDLE
    cfg_base = 32'h1000_0000; frame_start = 1'b1;
    cyc();
    frame_start = 1'b0; cfg_base = 32'hDEAD_BEE0;
`ifdef MEMMU_SR_WRITER_CLEAR_EN
    chk("clear_busy", 64'(busy), 64'd1);
    chk("clear_ready", 64'(sr_ready), 64'd0);
    wait_writes("clear_count", 16, 40);
    for (int i = 0; i < 16; i++) chk_write("clear_wr", i, 32'h1000_0000 + 32'(i * 8), 64'd0);
    chk("clear_done_ready", 64'(sr_ready), 64'd1);
    chk("clear_done_busy", 64'(busy), 64'd0);
    clear_log();
`else
    chk("stream_busy", 64'(busy), 64'd0);
    chk("stream_ready", 64'(sr_ready), 64'd1);
`endif
    chk("frame_pointcount", 64'(point_count), 64'd0);

    // Streaming table, back-to-back points
    for (int i = 0; i < 6; i++) begin
      sr_valid = 1'b1; sr_addr = vecs[i].idx; sr_payload = vecs[i].payload;
      if (i == 0) begin
        #1;
        chk("latency_no_same_cycle", 64'(wr_valid), 64'd0);
      end
      cyc();
    end
    sr_valid = 1'b0;
    wait_writes("stream_count", 6, 40);
    for (int i = 0; i < 6; i++) chk_write("stream_wr", i, vecs[i].exp_addr, vecs[i].payload);
    if (log_cyc.size() == 6) chk("stream_throughput", 64'(log_cyc[5] - log_cyc[0]), 64'd5);
    chk("stream_pointcount", 64'(point_count), 64'd6);

    // Backpressure: memory stalled 40 cycles, upstream always valid
    clear_log();
    wr_ready = 1'b0; k = 0; unstable = 0; first_addr = '0; first_data = '0;
    for (int c = 0; c < 40; c++) begin
      sr_valid = 1'b1; sr_addr = 19'(k); sr_payload = 64'h100 + 64'(k);
      @(negedge clk);
      acc = sr_ready;
      if (c == 1) begin
        first_addr = wr_addr; first_data = wr_data;
      end
      if (c >= 1 && (!wr_valid || wr_addr != first_addr || wr_data != first_data)) unstable++;
      @(posedge clk); #1;
      if (acc) k++;
    end
    chk("bp_accepts", 64'(k), 64'd16);
    chk("bp_ready_low", 64'(sr_ready), 64'd0);
    chk("bp_unstable", 64'(unstable), 64'd0);
    chk("bp_first_addr", 64'(first_addr), 64'h1000_0000);
    chk("bp_first_data", first_data, 64'h100);
    sr_valid = 1'b0; wr_ready = 1'b1;
    wait_writes("bp_count", 16, 60);
    for (int i = 0; i < 16; i++) chk_write("bp_wr", i, 32'h1000_0000 + 32'(i * 8), 64'h100 + 64'(i));
    chk("bp_pointcount", 64'(point_count), 64'd22);

    // Frame start with four points buffered
    clear_log();
    wr_ready = 1'b0;
    push_point(19'd2, 64'h200);
    push_point(19'd3, 64'h201);
    push_point(19'd4, 64'h202);
    push_point(19'd6, 64'h203);
    cfg_base = 32'h2000_0000; frame_start = 1'b1;
    cyc();
    frame_start = 1'b0; cfg_base = 32'h3000_0000;
    chk("drain_busy", 64'(busy), 64'd1);
    chk("drain_ready", 64'(sr_ready), 64'd0);
    frame_start = 1'b1;
    cyc();
    frame_start = 1'b0; cfg_base = 32'h4444_0000;
    wr_ready = 1'b1;
    wait_writes("drain_count", 4, 20);
    chk_write("drain_wr0", 0, 32'h1000_0010, 64'h200);
    chk_write("drain_wr1", 1, 32'h1000_0018, 64'h201);
    chk_write("drain_wr2", 2, 32'h1000_0020, 64'h202);
    chk_write("drain_wr3", 3, 32'h1000_0030, 64'h203);
    chk("drain_pointcount_old", 64'(point_count), 64'd26);
`ifdef MEMMU_SR_WRITER_CLEAR_EN
    wait_writes("drain_clear_count", 20, 40);
    for (int i = 0; i < 16; i++) chk_write("drain_clear_wr", 4 + i, 32'h2000_0000 + 32'(i * 8), 64'd0);
`else
    cyc();
`endif
    chk("newframe_busy", 64'(busy), 64'd0);
    chk("newframe_pointcount", 64'(point_count), 64'd0);
    clear_log();
    push_point(19'd3, 64'h55);
    wait_writes("newframe_count", 1, 20);
    chk_write("newframe_wr", 0, 32'h2000_0018, 64'h55);
    chk("newframe_pointcount1", 64'(point_count), 64'd1);

    // Reset with writes pending
    clear_log();
    wr_ready = 1'b0;
    push_point(19'd1, 64'h301);
    push_point(19'd2, 64'h302);
    push_point(19'd3, 64'h303);
    chk("pending_wrvalid", 64'(wr_valid), 64'd1);
    rst = 1'b1;
    cyc();
    chk("rstw_ready", 64'(sr_ready), 64'd0);
    rst = 1'b0;
    #1;
    chk("rstw_wrvalid", 64'(wr_valid), 64'd0);
    chk("rstw_busy", 64'(busy), 64'd0);
    chk("rstw_pointcount", 64'(point_count), 64'd0);
    chk("rstw_dropcount", 64'(drop_count), 64'd0);
    wr_ready = 1'b1;
    repeat (10) cyc();
    chk("rstw_no_writes", 64'(log_addr.size()), 64'd0);

`ifdef MEMMU_SR_WRITER_CLEAR_EN
    // Reset while the zero-fill presents index 7
    clear_log();
    cfg_base = 32'h5000_0000; frame_start = 1'b1;
    cyc();
    frame_start = 1'b0;
    wait_writes("rstc_prefix", 7, 20);
    chk("rstc_addr_idx7", 64'(wr_addr), 64'h5000_0038);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    #1;
    chk("rstc_wrvalid", 64'(wr_valid), 64'd0);
    chk("rstc_busy", 64'(busy), 64'd0);
    chk("rstc_pointcount", 64'(point_count), 64'd0);
    repeat (10) cyc();
    chk("rstc_no_more_writes", 64'(log_addr.size()), 64'd7);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
